// File: rtl/snn_infer_ctrl_pkg.sv
// Shared types, defaults and width helper for the spiking-network inference controller.
// Optional build macro used by the controller: SNN_FIRST_SPIKE_EXIT_EN.
package snn_infer_ctrl_pkg;

    localparam int DEF_INPUTS    = 25;
    localparam int DEF_NEURONS   = 2;
    localparam int DEF_TSTEPS    = 20;
    localparam int DEF_DRAIN_CYC = 2;
    localparam int DEF_CNT_W     = 5;
    localparam int DEF_WIN_W     = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4,
        ST_FLUSH = 3'd5
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2_min1(input int value);
        int bits;
        bits = 1;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/snn_argmax.sv
// Combinational arg-max over NEURONS packed CNT_W-bit counts: lowest winning index,
// tie flag (another index shares the maximum) and all-zero flag.
module snn_argmax
    import snn_infer_ctrl_pkg::*;
#(
    parameter int NEURONS = DEF_NEURONS,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int WIN_W   = DEF_WIN_W
) (
    input  logic [NEURONS*CNT_W-1:0] counts,
    output logic [WIN_W-1:0]         max_idx,
    output logic                     tie,
    output logic                     zero
);

    logic [CNT_W-1:0] best_s;
    logic [CNT_W-1:0] cur_s;
    logic [WIN_W-1:0] idx_s;
    logic             tie_s;

    // Strict greater-than keeps the lowest index on equal counts.
    always_comb begin
        best_s = counts[CNT_W-1:0];
        idx_s  = {WIN_W{1'b0}};
        tie_s  = 1'b0;
        cur_s  = {CNT_W{1'b0}};
        for (int i = 1; i < NEURONS; i++) begin
            cur_s = counts[i*CNT_W +: CNT_W];
            if (cur_s > best_s) begin
                best_s = cur_s;
                idx_s  = WIN_W'(i);
                tie_s  = 1'b0;
            end else if (cur_s == best_s) begin
                tie_s = 1'b1;
            end else begin
                tie_s = tie_s;
            end
        end
        zero    = (best_s == {CNT_W{1'b0}});
        max_idx = idx_s;
        if (zero) begin
            tie = 1'b0;
        end else begin
            tie = tie_s;
        end
    end

endmodule

// File: rtl/snn_infer_ctrl.sv
// Inference sequencer for the integrate-and-fire output layer: clear, stream frames, count, pick winner.
// Optional build macro: SNN_FIRST_SPIKE_EXIT_EN (exit on the first output spike, flushing the rest of the sample).
module snn_infer_ctrl
    import snn_infer_ctrl_pkg::*;
#(
    parameter int INPUTS    = DEF_INPUTS,
    parameter int NEURONS   = DEF_NEURONS,
    parameter int TSTEPS    = DEF_TSTEPS,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int WIN_W     = DEF_WIN_W
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               start,
    output logic               busy,
    input  logic               in_valid,
    input  logic [INPUTS-1:0]  in_data,
    output logic               in_ready,
    output logic [INPUTS-1:0]  signals,
    input  logic [NEURONS-1:0] spikes,
    output logic               latinhib,
    output logic               done,
    output logic [WIN_W-1:0]   winner,
    output logic               tie,
    output logic               no_spike
);

    localparam int FC_W = clog2_min1(TSTEPS + 1);
    localparam int DC_W = clog2_min1(DRAIN_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t                   state_r;
    logic [FC_W-1:0]          fcnt_r;
    logic [DC_W-1:0]          dcnt_r;
    logic [NEURONS*CNT_W-1:0] cnt_r;
    logic [NEURONS*CNT_W-1:0] cnt_next_s;
    logic [INPUTS-1:0]        signals_r;
    logic                     done_r;
    logic [WIN_W-1:0]         winner_r;
    logic                     tie_r;
    logic                     no_spike_r;

    logic                     count_en_s;
    logic                     in_ready_s;
    logic                     accept_s;
    logic                     last_accept_s;
    logic                     drain_last_s;
    logic [WIN_W-1:0]         am_idx_s;
    logic                     am_tie_s;
    logic                     am_zero_s;

    assign count_en_s    = (state_r == ST_RUN) || (state_r == ST_DRAIN);
`ifdef SNN_FIRST_SPIKE_EXIT_EN
    assign in_ready_s    = (state_r == ST_RUN) || (state_r == ST_FLUSH);
`else
    assign in_ready_s    = (state_r == ST_RUN);
`endif
    assign accept_s      = in_valid & in_ready_s;
    assign last_accept_s = accept_s && (fcnt_r == FC_W'(TSTEPS - 1));
    assign drain_last_s  = (dcnt_r == DC_W'(DRAIN_CYC - 1));

    assign busy     = (state_r != ST_IDLE);
    assign in_ready = in_ready_s;
    assign latinhib = (state_r == ST_CLEAR) | (|spikes);
    assign signals  = signals_r;
    assign done     = done_r;
    assign winner   = winner_r;
    assign tie      = tie_r;
    assign no_spike = no_spike_r;

    // Saturating per-neuron spike counters, including this edge's spikes.
    always_comb begin
        cnt_next_s = cnt_r;
        for (int i = 0; i < NEURONS; i++) begin
            if (count_en_s && spikes[i] && (cnt_r[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                cnt_next_s[i*CNT_W +: CNT_W] = cnt_r[i*CNT_W +: CNT_W] + CNT_W'(1);
            end else begin
                cnt_next_s[i*CNT_W +: CNT_W] = cnt_r[i*CNT_W +: CNT_W];
            end
        end
    end

    snn_argmax #(
        .NEURONS (NEURONS),
        .CNT_W   (CNT_W),
        .WIN_W   (WIN_W)
    ) u_argmax (
        .counts  (cnt_next_s),
        .max_idx (am_idx_s),
        .tie     (am_tie_s),
        .zero    (am_zero_s)
    );

`ifdef SNN_FIRST_SPIKE_EXIT_EN
    logic             fs_hit_s;
    logic [WIN_W-1:0] fs_idx_s;
    logic             fs_tie_s;
    logic             fs_found_s;

    // Lowest set spike bit and multi-spike flag for the early-exit result.
    always_comb begin
        fs_idx_s   = {WIN_W{1'b0}};
        fs_tie_s   = 1'b0;
        fs_found_s = 1'b0;
        for (int i = 0; i < NEURONS; i++) begin
            if (spikes[i] && !fs_found_s) begin
                fs_idx_s   = WIN_W'(i);
                fs_found_s = 1'b1;
            end else if (spikes[i]) begin
                fs_tie_s = 1'b1;
            end else begin
                fs_tie_s = fs_tie_s;
            end
        end
        fs_hit_s = count_en_s & fs_found_s;
    end
`endif

    // Sequencer state, frame streaming, counters and registered result.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_r    <= ST_IDLE;
            fcnt_r     <= {FC_W{1'b0}};
            dcnt_r     <= {DC_W{1'b0}};
            cnt_r      <= {(NEURONS*CNT_W){1'b0}};
            signals_r  <= {INPUTS{1'b0}};
            done_r     <= 1'b0;
            winner_r   <= {WIN_W{1'b0}};
            tie_r      <= 1'b0;
            no_spike_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_CLEAR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    cnt_r      <= {(NEURONS*CNT_W){1'b0}};
                    fcnt_r     <= {FC_W{1'b0}};
                    dcnt_r     <= {DC_W{1'b0}};
                    signals_r  <= {INPUTS{1'b0}};
                    winner_r   <= {WIN_W{1'b0}};
                    tie_r      <= 1'b0;
                    no_spike_r <= 1'b0;
                    state_r    <= ST_RUN;
                end
                ST_RUN: begin
                    cnt_r <= cnt_next_s;
                    if (accept_s) begin
                        signals_r <= in_data;
                        fcnt_r    <= fcnt_r + FC_W'(1);
                    end else begin
                        signals_r <= {INPUTS{1'b0}};
                    end
`ifdef SNN_FIRST_SPIKE_EXIT_EN
                    if (fs_hit_s) begin
                        winner_r   <= fs_idx_s;
                        tie_r      <= fs_tie_s;
                        no_spike_r <= 1'b0;
                        if (last_accept_s) begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_FLUSH;
                        end
                    end else
`endif
                    if (last_accept_s) begin
                        state_r <= ST_DRAIN;
                        dcnt_r  <= {DC_W{1'b0}};
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    cnt_r     <= cnt_next_s;
                    signals_r <= {INPUTS{1'b0}};
`ifdef SNN_FIRST_SPIKE_EXIT_EN
                    if (fs_hit_s) begin
                        winner_r   <= fs_idx_s;
                        tie_r      <= fs_tie_s;
                        no_spike_r <= 1'b0;
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                    end else
`endif
                    if (drain_last_s) begin
                        winner_r   <= am_idx_s;
                        tie_r      <= am_tie_s;
                        no_spike_r <= am_zero_s;
                        state_r    <= ST_DONE;
                        done_r     <= 1'b1;
                    end else begin
                        dcnt_r  <= dcnt_r + DC_W'(1);
                        state_r <= ST_DRAIN;
                    end
                end
`ifdef SNN_FIRST_SPIKE_EXIT_EN
                // Discard the rest of the sample so the next one starts aligned.
                ST_FLUSH: begin
                    signals_r <= {INPUTS{1'b0}};
                    if (accept_s) begin
                        fcnt_r <= fcnt_r + FC_W'(1);
                    end else begin
                        fcnt_r <= fcnt_r;
                    end
                    if (last_accept_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_FLUSH;
                    end
                end
`endif
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_infer_ctrl.sv
// Scoreboard bench for snn_infer_ctrl: expected results queued at start, popped by a done monitor.
module tb_snn_infer_ctrl;

    localparam int INPUTS    = 25;
    localparam int NEURONS   = 2;
    localparam int TSTEPS    = 20;
    localparam int DRAIN_CYC = 2;
    localparam int CNT_W     = 5;
    localparam int WIN_W     = 1;

    logic               clk = 1'b0;
    logic               rstb;
    logic               start;
    logic               busy;
    logic               in_valid;
    logic [INPUTS-1:0]  in_data;
    logic               in_ready;
    logic [INPUTS-1:0]  signals;
    logic [NEURONS-1:0] spikes;
    logic               latinhib;
    logic               done;
    logic [WIN_W-1:0]   winner;
    logic               tie;
    logic               no_spike;

    typedef struct {
        logic [WIN_W-1:0] w;
        logic             t;
        logic             z;
        int               edge_no;
    } exp_t;

    exp_t               sb[$];
    int                 n_pass = 0;
    int                 n_chk  = 0;
    int                 edge_cnt = 0;
    logic [NEURONS-1:0] spk_tab [1:TSTEPS];

    snn_infer_ctrl #(
        .INPUTS(INPUTS), .NEURONS(NEURONS), .TSTEPS(TSTEPS),
        .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W), .WIN_W(WIN_W)
    ) dut (
        .clk(clk), .rstb(rstb), .start(start), .busy(busy),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .signals(signals), .spikes(spikes), .latinhib(latinhib),
        .done(done), .winner(winner), .tie(tie), .no_spike(no_spike)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_cnt);
        end
    endtask

    // Result monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rstb === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("winner", 32'(winner), 32'(e.w));
                chk("tie", 32'(tie), 32'(e.t));
                chk("no_spike", 32'(no_spike), 32'(e.z));
                chk("done_edge", 32'(edge_cnt), 32'(e.edge_no));
            end
        end
    end

    task automatic clr_tab();
        for (int f = 1; f <= TSTEPS; f++) spk_tab[f] = 2'b00;
    endtask

    task automatic run_sample(input int stall_at, input int stall_len, input int abort_at,
                              input int start_at, input logic [1:0] clear_spk,
                              input logic [1:0] drain_spk, input logic [WIN_W-1:0] ew,
                              input logic et, input logic ez);
        int               e0;
        logic [INPUTS-1:0] fr;
        exp_t             e;
        start = 1'b1;
        @(posedge clk); #1;
        e0    = edge_cnt;
        start = 1'b0;
        if (abort_at == 0) begin
            e.w = ew; e.t = et; e.z = ez;
            e.edge_no = e0 + TSTEPS + DRAIN_CYC + 1 + stall_len;
            sb.push_back(e);
        end
        spikes = clear_spk;
        #1;
        chk("clear_latinhib", 32'(latinhib), 32'd1);
        chk("clear_in_ready", 32'(in_ready), 32'd0);
        chk("clear_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        for (int f = 1; f <= TSTEPS; f++) begin
            in_valid = 1'b1;
            in_data  = INPUTS'($urandom);
            fr       = in_data;
            spikes   = spk_tab[f];
            if (f == start_at) start = 1'b1;
            #1;
            chk("run_latinhib", 32'(latinhib), 32'(|spk_tab[f]));
            chk("run_in_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
            start = 1'b0;
            chk("signals_frame", 32'(signals), 32'(fr));
            if (f == start_at) chk("busy_after_start", 32'(busy), 32'd1);
            if (f == abort_at) begin
                rstb = 1'b0; in_valid = 1'b0; spikes = 2'b00;
                repeat (2) @(posedge clk);
                #1;
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_signals", 32'(signals), 32'd0);
                chk("rst_in_ready", 32'(in_ready), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                rstb = 1'b1;
                return;
            end
            if (f == stall_at) begin
                for (int b = 0; b < stall_len; b++) begin
                    in_valid = 1'b0;
                    in_data  = INPUTS'($urandom);
                    spikes   = 2'b00;
                    @(posedge clk); #1;
                    chk("bubble_signals", 32'(signals), 32'd0);
                end
            end
        end
        in_valid = 1'b0;
        for (int d = 1; d <= DRAIN_CYC; d++) begin
            spikes = drain_spk;
            #1;
            chk("drain_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
            if (d == 1) chk("drain_signals", 32'(signals), 32'd0);
        end
        spikes = 2'b00;
        @(posedge clk); #1;
        chk("post_done_low", 32'(done), 32'd0);
        chk("post_busy_low", 32'(busy), 32'd0);
        for (int k = 0; k < 50 && sb.size() != 0; k++) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rstb = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; spikes = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("por_busy", 32'(busy), 32'd0);
        chk("por_signals", 32'(signals), 32'd0);
        chk("por_in_ready", 32'(in_ready), 32'd0);
        chk("por_done", 32'(done), 32'd0);
        chk("por_winner", 32'(winner), 32'd0);
        chk("por_tie", 32'(tie), 32'd0);
        chk("por_no_spike", 32'(no_spike), 32'd0);
        rstb = 1'b1;
        @(posedge clk); #1;

        // Aborted sample with neuron 0 spiking, reset at frame 10.
        clr_tab();
        for (int f = 1; f <= 5; f++) spk_tab[f] = 2'b01;
        run_sample(0, 0, 10, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Nominal: n1=3, n0=1; start pulsed mid-run must be ignored.
        clr_tab();
        spk_tab[3] = 2'b10; spk_tab[8] = 2'b10; spk_tab[12] = 2'b10; spk_tab[15] = 2'b01;
        run_sample(0, 0, 0, 6, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0);

        // Five-cycle stall after frame 7; n0=1.
        clr_tab();
        spk_tab[2] = 2'b01;
        run_sample(7, 5, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0);

        // Tie: two spikes on each neuron (one simultaneous).
        clr_tab();
        spk_tab[4] = 2'b01; spk_tab[10] = 2'b11; spk_tab[17] = 2'b10;
        run_sample(0, 0, 0, 0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0);

        // No spikes at all.
        clr_tab();
        run_sample(0, 0, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1);

        // Spike during CLEAR is not counted: n1=1 alone wins.
        clr_tab();
        spk_tab[5] = 2'b10;
        run_sample(0, 0, 0, 0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0);

        // Spikes during both drain cycles are counted: n1=2 beats n0=1.
        clr_tab();
        spk_tab[1] = 2'b01;
        run_sample(0, 0, 0, 0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
